hazard_forward_unit: RTL

- Hazard-detection and forwarding-control stage beside the register-fetch/execute datapath.
- Tracks destination metadata of the instructions in the EX and MEM slots.
- For the instruction currently in decode, drives forwardCondA/forwardCondB using the datapath's 2-bit mux encoding, and raises stall on a load-use hazard.
- The datapath buffers forwardCond one cycle, so the outputs describe the decode-stage instruction.

---
 rtl/hazard_forward_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// hazard_forward_unit: EX/MEM destination tracking, forward-mux select, load-use stall.
// Optional HAZARD_STATS_EN adds saturating stall/forward/flush counters. Rev 1.0
// ============================================================================
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int ZR_IDX = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_Rn,
  input  logic [REG_AW-1:0] id_Rm,
  input  logic [REG_AW-1:0] id_Rd,
  input  logic              id_Reg2Loc,
  input  logic              id_useA,
  input  logic              id_useB,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_Move,
  input  logic              flush,
  output logic [1:0]        forwardCondA,
  output logic [1:0]        forwardCondB,
  output logic              stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       fwd_count,
  output logic [15:0]       flush_count
`endif
);

  localparam logic [REG_AW-1:0] ZR = ZR_IDX[REG_AW-1:0];

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wr;
    logic              load;
    logic              move;
  } slot_t;

  slot_t             ex_slot, mem_slot;
  logic [REG_AW-1:0] src_b;
  logic              ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic              load_use;

  function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] src);
    return s.valid & s.wr & (s.dest == src) & (src != ZR);
  endfunction

  // A load still in EX has no result yet: select regfile and let the stall retry.
  function automatic logic [1:0] fwd_code(input logic use_src, input logic ex_m,
                                          input logic mem_m, input slot_t ex);
    if (!use_src)           return 2'b00;
    else if (ex_m && ex.move) return 2'b11;
    else if (ex_m && ex.load) return 2'b00;
    else if (ex_m)          return 2'b01;
    else if (mem_m)         return 2'b10;
    else                    return 2'b00;
  endfunction

  always_comb begin
    src_b        = id_Reg2Loc ? id_Rm : id_Rd;
    ex_match_a   = slot_match(ex_slot, id_Rn);
    ex_match_b   = slot_match(ex_slot, src_b);
    mem_match_a  = slot_match(mem_slot, id_Rn);
    mem_match_b  = slot_match(mem_slot, src_b);
    forwardCondA = fwd_code(id_useA, ex_match_a, mem_match_a, ex_slot);
    forwardCondB = fwd_code(id_useB, ex_match_b, mem_match_b, ex_slot);
    // id_valid gates first so undefined decode fields cannot reach stall.
    load_use     = id_valid & ex_slot.load &
                   ((id_useA & ex_match_a) | (id_useB & ex_match_b));
    stall        = load_use & ~flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= ex_slot;
      if (id_valid && !stall && !flush) begin
        ex_slot.valid <= 1'b1;
        ex_slot.dest  <= id_Rd;
        ex_slot.wr    <= id_RegWrite;
        ex_slot.load  <= id_MemRead;
        ex_slot.move  <= id_Move;
      end else begin
        ex_slot <= '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      if (((forwardCondA != 2'b00) || (forwardCondB != 2'b00)) && (fwd_count != '1))
        fwd_count <= fwd_count + 32'd1;
      if (flush && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
